// File: rtl/instr_fetch_responder_pkg.sv
// rtl/instr_fetch_responder_pkg.sv - shared types for the instruction fetch responder
package instr_fetch_responder_pkg;

    localparam int W = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    typedef logic [1:0] lane_t;

endpackage

// File: rtl/instr_fetch_responder_buffer.sv
// rtl/instr_fetch_responder_buffer.sv - one-entry last-word buffer with tag compare
module fetch_word_buffer
    import instr_fetch_responder_pkg::*;
#(
    parameter int TAGW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inval,
    input  logic            wr_en,
    input  logic [TAGW-1:0] wr_tag,
    input  logic [W-1:0]    wr_data,
    input  logic [TAGW-1:0] lookup_tag,
    output logic            hit,
    output logic [W-1:0]    rd_data
);

    logic            valid_q, valid_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic [W-1:0]    data_q, data_d;

    // Next entry: a write refills the entry, invalidate always overrides valid.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d = 1'b1;
            tag_d   = wr_tag;
            data_d  = wr_data;
        end
        if (inval) begin
            valid_d = 1'b0;
        end
    end

    // Entry registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    // A same-cycle invalidate must turn a would-be hit into a miss.
    assign hit     = valid_q && !inval && (tag_q == lookup_tag);
    assign rd_data = data_q;

endmodule

// File: rtl/instr_fetch_responder.sv
// rtl/instr_fetch_responder.sv - serves 32-bit fetches from a byte-wide memory
module instr_fetch_responder
    import instr_fetch_responder_pkg::*;
#(
    parameter int MEMAW = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instrreq,
    input  logic [31:0]      instradr,
    output logic [31:0]      instrF,
    output logic             instrabort,
    input  logic             inval,
    output logic             mem_re,
    output logic [MEMAW-1:0] mem_adr,
    input  logic [7:0]       mem_rdata,
    input  logic             mem_ack
);

    localparam int TAGW = MEMAW - 2;

    state_e          state_q, state_d;
    logic [TAGW-1:0] word_q, word_d;
    lane_t           idx_q, idx_d;
    logic [W-1:0]    asm_q, asm_d;
    logic [W-1:0]    instr_f_q, instr_f_d;
    logic            abort_q, abort_d;
    logic            mem_re_q, mem_re_d;

    logic            buf_wr;
    logic            buf_hit;
    logic [W-1:0]    buf_data;
    logic [TAGW-1:0] req_tag;

    logic            unused_adr_bits;
    assign unused_adr_bits = ^{instradr[31:MEMAW], instradr[1:0]};

    assign req_tag = instradr[MEMAW-1:2];

    fetch_word_buffer #(.TAGW(TAGW)) u_buf (
        .clk        (clk),
        .reset      (reset),
        .inval      (inval),
        .wr_en      (buf_wr),
        .wr_tag     (word_q),
        .wr_data    (instr_f_d),
        .lookup_tag (req_tag),
        .hit        (buf_hit),
        .rd_data    (buf_data)
    );

    // Fetch FSM: buffer lookup, four big-endian byte reads, then hold until released.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        idx_d     = idx_q;
        asm_d     = asm_q;
        instr_f_d = instr_f_q;
        mem_re_d  = mem_re_q;
        buf_wr    = 1'b0;
        // Abort falls one cycle after DONE is reached and rises as soon as the request drops.
        abort_d   = !(state_q == S_DONE && instrreq);
        case (state_q)
            S_IDLE: begin
                if (instrreq) begin
                    if (buf_hit) begin
                        instr_f_d = buf_data;
                        state_d   = S_DONE;
                    end else begin
                        word_d   = req_tag;
                        idx_d    = 2'd0;
                        mem_re_d = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    asm_d[{~idx_q, 3'b000} +: 8] = mem_rdata;
                    if (!instrreq) begin
                        mem_re_d = 1'b0;
                        state_d  = S_IDLE;
                    end else if (idx_q == 2'd3) begin
                        mem_re_d  = 1'b0;
                        instr_f_d = asm_d;
                        buf_wr    = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        idx_d = lane_t'(idx_q + 2'd1);
                    end
                end
            end
            S_DONE: begin
                if (!instrreq) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                mem_re_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            word_q    <= '0;
            idx_q     <= 2'd0;
            asm_q     <= '0;
            instr_f_q <= '0;
            abort_q   <= 1'b1;
            mem_re_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            idx_q     <= idx_d;
            asm_q     <= asm_d;
            instr_f_q <= instr_f_d;
            abort_q   <= abort_d;
            mem_re_q  <= mem_re_d;
        end
    end

    assign instrF     = instr_f_q;
    assign instrabort = abort_q;
    assign mem_re     = mem_re_q;
    assign mem_adr    = {word_q, idx_q};

endmodule

// File: doc/instr_fetch_responder.md
Name: instr_fetch_responder

Overview:
- Memory-side responder for the datapath's instruction-fetch handshake (instrreq / instradr / instrF / instrabort).
- Assembles each 32-bit instruction word from four reads of a byte-wide backing memory with a req/ack handshake.
- Holds a one-entry last-word buffer so a repeated fetch of the same word is served without memory traffic.
- Sits between the datapath's fetch port and the instruction ROM/RAM.

Parameters:
- MEMAW, 10, byte-address width of backing memory (1 KiB default)
- W, 32, instruction word width (fixed at 32; 4 bytes)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- instrreq  input  1  fetch request from datapath, level; held until instrabort seen low
- instradr  input  32  fetch byte address; sampled when request accepted
- instrF  output  32  fetched instruction, registered
- instrabort  output  1  1 = response not ready; 0 = instrF valid, initiator may consume and drop instrreq
- inval  input  1  invalidate last-word buffer
- mem_re  output  1  byte read request to backing memory, level, held until mem_ack
- mem_adr  output  MEMAW  byte address to backing memory
- mem_rdata  input  8  read byte, valid with mem_ack
- mem_ack  input  1  one-cycle read completion strobe

Behaviour:
- Interface: one clock; reset is asynchronous and active-high; ports named clk and reset.
- Reset values: state IDLE, instrF=0, instrabort=1, mem_re=0, mem_adr=0, byte index=0, buffer valid=0, buffer tag=0.
- Alignment: instradr[1:0] ignored; word address = instradr[MEMAW-1:2]; bits above MEMAW-1 ignored (tag compares instradr[MEMAW-1:2] only).
- Byte order big-endian: byte at offset 0 -> instrF[31:24], offset 3 -> instrF[7:0].
- States:
  - IDLE: instrabort=1.
    - instrreq=1 and buffer hit (valid and tag match) -> DONE next cycle; instrF loaded from buffer.
    - instrreq=1 and miss -> FETCH; latch word address; byte index=0; mem_re=1, mem_adr={word,2'b00} from the next cycle.
  - FETCH: mem_re=1; mem_adr={word, index}.
    - On mem_ack: write mem_rdata into byte lane index of the assembly register.
    - Index <3: index+1; mem_re stays 1; address updates on the next cycle.
    - Index =3 and instrreq=1: instrF = assembled word; buffer tag = word; buffer valid=1; -> DONE.
    - Index =3 and instrreq=0: -> IDLE; buffer and instrF unchanged.
  - DONE: instrabort=0; instrF stable.
    - instrreq=0 -> IDLE with instrabort=1 on the next cycle.
    - instrreq held high -> stay in DONE; no new fetch until instrreq has been low for at least one cycle.
- Request dropped mid-fetch (instrreq=0 in FETCH before the last byte):
  - The outstanding byte read completes, because mem_re is never withdrawn before mem_ack.
  - After that ack: mem_re=0, -> IDLE, no buffer update.
- Latency:
  - Hit: instrabort low 2 cycles after instrreq is sampled high.
  - Miss with zero-wait memory (ack the cycle after mem_re): instrabort low 6 cycles after request.
  - General miss: 2 + sum of per-byte ack latencies.
- inval: clears buffer valid on the next edge in any state.
  - If inval and completion of a fetch coincide, inval wins: valid=0 while instrF is still delivered.
  - inval in IDLE in the same cycle as a request forces a miss.
- mem_ack outside FETCH: ignored.
- Reset mid-fetch: immediate return to reset values; mem_re drops asynchronously.

Decomposition:
- Shared package: state enum (IDLE, FETCH, DONE) and byte-lane index type (2 bits).
- One sub-module is natural: fetch_word_buffer (tag/valid/data register with hit compare and inval).
- The FSM and byte assembly stay in the top module.

Test Plan:
- Miss, zero-wait memory with bytes 0x00..0x03 = 8C,01,00,04; instradr=0x0 -> mem_adr 0,1,2,3 in order; instrF=0x8C010004; instrabort low 6 cycles after request.
- Hit: repeat instradr=0x0 (also 0x2, misaligned) -> no mem_re; instrF=0x8C010004; instrabort low 2 cycles after request.
- Variable latency: mem_ack delayed 3,0,5,1 cycles at instradr=0x10 -> mem_re high continuously, mem_adr stable until each ack; correct word; instrabort stays 1 throughout.
- Drop mid-fetch: instrreq falls after the 2nd ack at instradr=0x20 -> 3rd byte still acked; mem_re=0, state IDLE; next request to 0x20 misses and refetches all 4 bytes.
- inval coinciding with last ack at instradr=0x40 -> instrF delivered; immediate re-request to 0x40 misses.
- Async reset asserted while in FETCH -> mem_re=0, instrabort=1, instrF=0 before next clk edge; buffer invalid afterwards.
